// File: rtl/order_request_dispatcher.sv
// Buffers decoded market messages and issues them one at a time to order_book_wrapper
// over its start/is_busy handshake. Optional counters behind DISPATCH_STATS_EN.
module order_request_dispatcher #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT        = 64,
   parameter int NUM_STOCKS     = 3,
   parameter int STOCK_INDEX    = 1,
   parameter int QUANTITY_INDEX = 15,
   parameter int ORDER_INDEX    = 15,
   parameter int ENTRY_W        = 32
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   input  logic [STOCK_INDEX:0]      msg_stock,
   input  logic [ENTRY_W-1:0]        msg_entry,
   input  logic [2:0]                msg_request,
   input  logic                      msg_delete,
   input  logic [QUANTITY_INDEX:0]   msg_quantity,
   input  logic [ORDER_INDEX:0]      msg_order_id,
   input  logic                      ob_is_busy,
   output logic                      ob_start,
   output logic [STOCK_INDEX:0]      ob_stock,
   output logic [ENTRY_W-1:0]        ob_entry,
   output logic [2:0]                ob_request,
   output logic                      ob_delete,
   output logic [QUANTITY_INDEX:0]   ob_quantity,
   output logic [ORDER_INDEX:0]      ob_order_id,
   output logic                      dispatch_busy,
   output logic                      timeout_err
`ifdef DISPATCH_STATS_EN
   ,
   output logic [15:0]               issued_cnt,
   output logic [15:0]               dropped_cnt
`endif
);

   // state       | meaning
   // S_IDLE      | pop head when FIFO non-empty and wrapper idle; drop bad stock
   // S_ISSUE     | start pulse is high for this single cycle
   // S_WAIT_BUSY | waiting up to 2 cycles for the wrapper to raise is_busy
   // S_WAIT_DONE | wrapper owns the request; down-timer guards a hung book
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [STOCK_INDEX:0]    stock;
      logic [ENTRY_W-1:0]      entry;
      logic [2:0]              request;
      logic                    del;
      logic [QUANTITY_INDEX:0] quantity;
      logic [ORDER_INDEX:0]    order_id;
   } req_t;

   localparam int AW      = $clog2(DEPTH);
   localparam int PTR_W   = AW + 1;
   localparam int TMR_W   = $clog2(TIMEOUT) + 1;
   localparam int STK_W   = STOCK_INDEX + 2;
   localparam logic [STK_W-1:0] NUM_STOCKS_W = STK_W'(NUM_STOCKS);

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   req_t              fifo_mem [DEPTH];
   req_t              msg_word, head;
   logic              fifo_empty, fifo_full;
   logic              push, pop, load, drop, err_set, head_bad;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign msg_ready  = !fifo_full;
   assign push       = msg_valid && msg_ready;

   assign msg_word = {msg_stock, msg_entry, msg_request, msg_delete, msg_quantity, msg_order_id};
   assign head     = fifo_mem[rd_ptr[AW-1:0]];
   assign head_bad = ({1'b0, head.stock} >= NUM_STOCKS_W);

   assign dispatch_busy = (state != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= msg_word;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
      end
   end

   // One shared down-timer: 2 cycles for acknowledge, TIMEOUT cycles for completion.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      pop       = 1'b0;
      load      = 1'b0;
      drop      = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && !ob_is_busy) begin
               pop = 1'b1;
               if (head_bad) begin
                  drop = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_BUSY;
            tmr_nxt   = TMR_W'(1);
         end
         S_WAIT_BUSY: begin
            if (ob_is_busy) begin
               state_nxt = S_WAIT_DONE;
               tmr_nxt   = TMR_W'(TIMEOUT - 1);
            end else if (tmr == '0) begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!ob_is_busy) begin
               state_nxt = S_IDLE;
            end else if (tmr == '0) begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ob_start    <= 1'b0;
         ob_stock    <= '0;
         ob_entry    <= '0;
         ob_request  <= '0;
         ob_delete   <= 1'b0;
         ob_quantity <= '0;
         ob_order_id <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         ob_start <= load;
         // Fields only move on a load, so they stay put while the wrapper owns them.
         if (load) begin
            ob_stock    <= head.stock;
            ob_entry    <= head.entry;
            ob_request  <= head.request;
            ob_delete   <= head.del;
            ob_quantity <= head.quantity;
            ob_order_id <= head.order_id;
         end
         if (err_set) begin
            timeout_err <= 1'b1;
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         issued_cnt  <= '0;
         dropped_cnt <= '0;
      end else begin
         if (load && (issued_cnt != 16'hFFFF)) begin
            issued_cnt <= issued_cnt + 16'd1;
         end
         if (drop && (dropped_cnt != 16'hFFFF)) begin
            dropped_cnt <= dropped_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_order_request_dispatcher.sv
// Bench for order_request_dispatcher: directed scenarios plus a random run checked
// against an in-order queue of the requests the wrapper should receive.
`timescale 1ns/1ps
module tb_order_request_dispatcher;
   localparam int DEPTH          = 4;
   localparam int TIMEOUT        = 16;
   localparam int NUM_STOCKS     = 3;
   localparam int STOCK_INDEX    = 1;
   localparam int QUANTITY_INDEX = 15;
   localparam int ORDER_INDEX    = 15;
   localparam int ENTRY_W        = 32;

   typedef struct packed {
      logic [STOCK_INDEX:0]    stock;
      logic [ENTRY_W-1:0]      entry;
      logic [2:0]              request;
      logic                    del;
      logic [QUANTITY_INDEX:0] quantity;
      logic [ORDER_INDEX:0]    order_id;
   } req_t;

   logic                    clk_in, rst_in, msg_valid, msg_ready;
   logic [STOCK_INDEX:0]    msg_stock, ob_stock;
   logic [ENTRY_W-1:0]      msg_entry, ob_entry;
   logic [2:0]              msg_request, ob_request;
   logic                    msg_delete, ob_delete;
   logic [QUANTITY_INDEX:0] msg_quantity, ob_quantity;
   logic [ORDER_INDEX:0]    msg_order_id, ob_order_id;
   logic                    ob_is_busy, ob_start, dispatch_busy, timeout_err;
`ifdef DISPATCH_STATS_EN
   logic [15:0]             issued_cnt, dropped_cnt;
`endif

   order_request_dispatcher #(
      .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .NUM_STOCKS(NUM_STOCKS),
      .STOCK_INDEX(STOCK_INDEX), .QUANTITY_INDEX(QUANTITY_INDEX),
      .ORDER_INDEX(ORDER_INDEX), .ENTRY_W(ENTRY_W)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_stock(msg_stock), .msg_entry(msg_entry), .msg_request(msg_request),
      .msg_delete(msg_delete), .msg_quantity(msg_quantity), .msg_order_id(msg_order_id),
      .ob_is_busy(ob_is_busy), .ob_start(ob_start),
      .ob_stock(ob_stock), .ob_entry(ob_entry), .ob_request(ob_request),
      .ob_delete(ob_delete), .ob_quantity(ob_quantity), .ob_order_id(ob_order_id),
      .dispatch_busy(dispatch_busy), .timeout_err(timeout_err)
`ifdef DISPATCH_STATS_EN
      , .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_start = 0;
   int   n_ok = 0;
   int   n_bad = 0;
   int   start_cyc[$];
   req_t exp_q[$];
   int   wr_hold = 3;
   bit   wr_ack = 1'b1;
   bit   wr_stall = 1'b0;
   int   busy_left = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic req_t cur_fields();
      return {ob_stock, ob_entry, ob_request, ob_delete, ob_quantity, ob_order_id};
   endfunction

   // Wrapper model: busy rises the cycle after start and stays up for wr_hold cycles.
   initial begin : wrapper
      ob_is_busy = 1'b0;
      forever begin
         @(posedge clk_in);
         #2;
         if (rst_in) begin
            busy_left  = 0;
            ob_is_busy = 1'b0;
         end else begin
            if (wr_stall) ob_is_busy = 1'b1;
            else if (busy_left > 0) begin
               ob_is_busy = 1'b1;
               busy_left--;
            end else ob_is_busy = 1'b0;
            if (ob_start && wr_ack) busy_left = wr_hold;
         end
      end
   end

   initial begin : monitor
      req_t last;
      bit   have_last;
      bit   start_prev;
      have_last  = 1'b0;
      start_prev = 1'b0;
      last       = '0;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (rst_in) begin
            have_last  = 1'b0;
            start_prev = 1'b0;
         end else begin
            if (ob_start) begin
               chk("start_back_to_back", start_prev, 0);
               chk("start_while_busy", ob_is_busy, 0);
               chk("start_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  chk("issue_fields", cur_fields(), exp_q[0]);
                  void'(exp_q.pop_front());
               end
               n_start++;
               start_cyc.push_back(cyc);
               last      = cur_fields();
               have_last = 1'b1;
            end else if (have_last) begin
               chk("fields_stable", cur_fields(), last);
            end
            start_prev = ob_start;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic push_req(input req_t r);
      int n = 0;
      bit acc;
      msg_valid    = 1'b1;
      msg_stock    = r.stock;
      msg_entry    = r.entry;
      msg_request  = r.request;
      msg_delete   = r.del;
      msg_quantity = r.quantity;
      msg_order_id = r.order_id;
      while (!msg_ready && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      acc = msg_ready;
      chk("push_accept", acc, 1);
      @(posedge clk_in);
      if (acc) begin
         if (int'(r.stock) < NUM_STOCKS) begin
            exp_q.push_back(r);
            n_ok++;
         end else n_bad++;
      end
      @(negedge clk_in);
      msg_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((dispatch_busy || ob_is_busy) && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      chk(tag, dispatch_busy, 0);
   endtask

   task automatic chk_reset_outputs(input string p);
      chk({p, "_ready"}, msg_ready, 1);
      chk({p, "_start"}, ob_start, 0);
      chk({p, "_fields"}, cur_fields(), 0);
      chk({p, "_dbusy"}, dispatch_busy, 0);
      chk({p, "_err"}, timeout_err, 0);
`ifdef DISPATCH_STATS_EN
      chk({p, "_stats"}, {issued_cnt, dropped_cnt}, 0);
`endif
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      exp_q.delete();
      tick(2);
      rst_in = 1'b0;
      tick(1);
   endtask

   function automatic req_t rand_req(input bit valid_only);
      req_t r;
      r.stock    = valid_only ? 2'($urandom_range(0, NUM_STOCKS - 1)) : 2'($urandom_range(0, 3));
      r.entry    = $urandom;
      r.request  = 3'($urandom_range(0, 7));
      r.del      = 1'($urandom_range(0, 1));
      r.quantity = 16'($urandom);
      r.order_id = 16'($urandom);
      return r;
   endfunction

   initial begin : main
      req_t r, r2;
      int base, n, ok0, bad0;
      rst_in = 1'b1;
      msg_valid = 1'b0;
      msg_stock = '0; msg_entry = '0; msg_request = '0;
      msg_delete = 1'b0; msg_quantity = '0; msg_order_id = '0;
      tick(3);
      chk_reset_outputs("reset");
      rst_in = 1'b0;
      tick(1);

      // single request, wrapper busy 3 cycles
      wr_hold = 3;
      base = n_start;
      r = '{stock: 2'd1, entry: 32'hABCD0001, request: 3'd2, del: 1'b0, quantity: 16'd10, order_id: 16'd5};
      push_req(r);
      chk("single_head_busy", dispatch_busy, 1);
      chk("single_no_early_start", ob_start, 0);
      tick(1);
      chk("single_start_latency", ob_start, 1);
      n = 0;
      while (!ob_is_busy && n < 10) begin tick(1); n++; end
      while (ob_is_busy && n < 20) begin tick(1); n++; end
      chk("single_dbusy_at_fall", dispatch_busy, 1);
      tick(1);
      chk("single_dbusy_after_fall", dispatch_busy, 0);
      chk("single_one_start", n_start - base, 1);
      chk("single_fields", {ob_stock, ob_quantity, ob_order_id}, {2'd1, 16'd10, 16'd5});

      // back-to-back: minimum issue interval
      wr_hold = 1;
      base = n_start;
      push_req(rand_req(1'b1));
      push_req(rand_req(1'b1));
      wait_idle("b2b_idle", 50);
      chk("b2b_starts", n_start - base, 2);
      chk("b2b_interval", start_cyc[start_cyc.size() - 1] - start_cyc[start_cyc.size() - 2], 4);

      // FIFO full with wrapper stalled busy
      wr_hold = 2;
      wr_stall = 1'b1;
      tick(2);
      base = n_start;
      for (int i = 0; i < DEPTH; i++) push_req(rand_req(1'b1));
      chk("full_ready_low", msg_ready, 0);
      chk("full_no_start", n_start - base, 0);
      fork
         push_req(rand_req(1'b1));
         begin tick(5); wr_stall = 1'b0; end
      join
      wait_idle("full_idle", 200);
      chk("full_all_issued", n_start - base, DEPTH + 1);
      chk("full_queue_drained", exp_q.size(), 0);

      // out-of-range stock dropped
      base = n_start;
`ifdef DISPATCH_STATS_EN
      bad0 = int'(dropped_cnt);
`endif
      r = rand_req(1'b1); r.stock = 2'(NUM_STOCKS);
      push_req(r);
      r = rand_req(1'b1); r.stock = 2'd0;
      push_req(r);
      wait_idle("inv_idle", 50);
      chk("inv_one_start", n_start - base, 1);
      chk("inv_stock0", ob_stock, 0);
`ifdef DISPATCH_STATS_EN
      chk("inv_dropped_cnt", int'(dropped_cnt) - bad0, 1);
`endif

      // no acknowledge: 2 cycles in WAIT_BUSY, error, back to idle
      do_reset();
      wr_ack = 1'b0;
      push_req(rand_req(1'b1));
      tick(1);
      chk("noack_start", ob_start, 1);
      tick(2);
      chk("noack_err_not_yet", timeout_err, 0);
      tick(1);
      chk("noack_err", timeout_err, 1);
      chk("noack_idle", dispatch_busy, 0);
      wr_ack = 1'b1;
      wr_hold = 2;
      base = n_start;
      push_req(rand_req(1'b1));
      wait_idle("noack_next_idle", 50);
      chk("noack_next_start", n_start - base, 1);

      // wrapper busy for TIMEOUT+5 cycles
      do_reset();
      wr_hold = TIMEOUT + 5;
      base = n_start;
      push_req(rand_req(1'b1));
      push_req(rand_req(1'b1));
      chk("to_start", ob_start, 1);
      tick(TIMEOUT + 1);
      chk("to_err_not_yet", timeout_err, 0);
      tick(1);
      chk("to_err", timeout_err, 1);
      wait_idle("to_idle", 200);
      chk("to_next_dispatched", n_start - base, 2);
      chk("to_err_sticky", timeout_err, 1);

      // reset mid-WAIT_DONE with 2 requests queued
      do_reset();
      wr_hold = 50;
      push_req(rand_req(1'b1));
      push_req(rand_req(1'b1));
      push_req(rand_req(1'b1));
      tick(2);
      chk("mid_wrapper_busy", ob_is_busy, 1);
      chk("mid_dbusy", dispatch_busy, 1);
      base = n_start;
      rst_in = 1'b1;
      exp_q.delete();
      tick(1);
      chk_reset_outputs("mid_reset");
      rst_in = 1'b0;
      tick(20);
      chk("mid_no_starts", n_start - base, 0);
      chk("mid_dbusy_after", dispatch_busy, 0);

      // random traffic against the in-order model
      do_reset();
      base = n_start;
      ok0 = n_ok;
      bad0 = n_bad;
      for (int i = 0; i < 40; i++) begin
         wr_hold = $urandom_range(1, 4);
         push_req(rand_req(1'b0));
         tick($urandom_range(0, 3));
      end
      wait_idle("rand_idle", 500);
      chk("rand_queue_drained", exp_q.size(), 0);
      chk("rand_starts", n_start - base, n_ok - ok0);
      chk("rand_no_err", timeout_err, 0);
`ifdef DISPATCH_STATS_EN
      chk("rand_issued_cnt", issued_cnt, n_ok - ok0);
      chk("rand_dropped_cnt", dropped_cnt, n_bad - bad0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/order_request_dispatcher.md
# order_request_dispatcher

Initiator side of the order-book request handshake: buffers decoded market messages from the feed parser in a small FIFO and issues them one at a time to `order_book_wrapper` using its `start` / `is_busy` protocol. It drops requests for out-of-range stocks, holds request fields stable for the whole transaction, and watches for a hung book with a timeout. It sits between the message decoder and `order_book_wrapper`.

## Interface
Parameters
- `DEPTH`, 4: request FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, 64: maximum cycles allowed in WAIT_DONE before the error flag is raised.

Ports
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `msg_valid`  in  1  decoder has a request.
- `msg_ready`  out  1  FIFO can accept; equals `!full`.
- `msg_stock`  in  STOCK_INDEX+1  target stock.
- `msg_entry`  in  book_entry  order payload.
- `msg_request`  in  3  request code.
- `msg_delete`  in  1  delete flag.
- `msg_quantity`  in  QUANTITY_INDEX+1  quantity.
- `msg_order_id`  in  ORDER_INDEX+1  order id.
- `ob_is_busy`  in  1  `is_busy` from the wrapper.
- `ob_start`  out  1  one-cycle start pulse.
- `ob_stock`, `ob_entry`, `ob_request`, `ob_delete`, `ob_quantity`, `ob_order_id`  out  same widths as the `msg_*` ports  registered request fields.
- `dispatch_busy`  out  1  high when state is not IDLE or the FIFO is not empty.
- `timeout_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- **FIFO write:** a request is written on `msg_valid && msg_ready`.
- **FIFO storage:** head/tail pointers have width log2(DEPTH)+1. The extra MSB tells full from empty.
- **IDLE:**
  - Pop happens when the FIFO is non-empty and `!ob_is_busy`.
  - If the popped `stock >= NUM_STOCKS`, the entry is discarded and the state stays IDLE. The wrapper never accepts such a request.
  - Otherwise all `ob_*` fields are loaded, `ob_start` is set to 1, and the state goes to ISSUE.
- **ISSUE** (exactly 1 cycle): `ob_start` is set back to 0 and the state goes to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `ob_is_busy`=1, go to WAIT_DONE.
  - If `ob_is_busy` stays 0 for 2 cycles, set `timeout_err` and go to IDLE.
- **WAIT_DONE:**
  - If `ob_is_busy`=0, go to IDLE.
  - The timeout counter resets on entry. When it reaches TIMEOUT-1 with busy still high, set `timeout_err` and go to IDLE.
- The `ob_*` fields hold their values from the load until the next load. They never change while the wrapper owns the request.
- **Simultaneous push and pop:** both are allowed in the same cycle. When the FIFO is full, `msg_ready` is 0, even if a pop happens that same cycle.

## Timing
- **Reset values:**
  - State is IDLE and the FIFO is empty.
  - `msg_ready`=1.
  - `ob_start`=0, and every `ob_*` field is 0.
  - `dispatch_busy`=0 and `timeout_err`=0.
- **Reset mid-transaction:** the FIFO contents and any in-flight request are discarded. No start is issued for them.
- **Push-to-start latency:** a push at edge k makes the entry visible at the head in cycle k+1. `ob_start` is high in cycle k+2 if the dispatcher is idle.
- **Back-to-back requests:** the minimum issue interval is 4 cycles: start, busy observed, busy falls, then IDLE pops again.
- **Start pulse:** `ob_start` is never high for 2 consecutive cycles, and is never asserted while `ob_is_busy`=1.

## Configuration
- `DISPATCH_STATS_EN` defined: adds output ports `issued_cnt[15:0]` and `dropped_cnt[15:0]`.
  - `issued_cnt` increments on each start.
  - `dropped_cnt` increments on each out-of-range discard.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the counters and their ports do not exist. All other behaviour is identical.

## Test plan
- **Single request:** push stock=1, qty=10, id=5; the wrapper model asserts busy 1 cycle after start and holds it 3 cycles. Required: exactly one start pulse, `ob_stock`=1, `ob_quantity`=10, `ob_order_id`=5 stable throughout, and `dispatch_busy` falls after busy falls.
- **FIFO full:** push DEPTH+1 requests back-to-back with the wrapper stalled busy. Required: `msg_ready`=0 after DEPTH entries, no loss, and issue order matches push order.
- **Invalid stock:** push stock=NUM_STOCKS, then stock=0. Required: no start for the first and a start for the second; `dropped_cnt`=1 when the macro is defined.
- **Busy timeout:** the wrapper holds busy for TIMEOUT+5 cycles. Required: `timeout_err`=1 after TIMEOUT cycles in WAIT_DONE, and the next request is still dispatched.
- **No acknowledge:** the wrapper never raises busy. Required: `timeout_err`=1 two cycles after ISSUE, and the state returns to IDLE.
- **Reset mid-WAIT_DONE with 2 entries queued:** required: all outputs at reset values next cycle, and no further starts.
